// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The default widths here match the top-level parameter defaults.
package if_pkg;

  localparam int unsigned IF_ADDR_W  = 32;
  localparam int unsigned IF_INSTR_W = 32;
  localparam int unsigned PC_STEP    = 4;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_KILL = 3'd3,
    S_HOLD = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_ADDR_W-1:0]  pc_plus4;
    logic [IF_INSTR_W-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit_ifid_reg.sv
// Generic pipeline register with load/hold/flush; flush only clears valid.
// Flush wins over load so a redirect can never be overridden by late data.
module ifid_reg #(
  parameter int unsigned DATA_WIDTH = 96
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the PC register's next value, issues one
// outstanding imem request at a time, and fills the IF/ID register.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic [ADDR_WIDTH-1:0]  pc_next_o,
  if_fetch_unit_if.master        imem,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   ifid_valid_o,
  output logic [ADDR_WIDTH-1:0]  ifid_pc_o,
  output logic [ADDR_WIDTH-1:0]  ifid_pc_plus4_o,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o
);

  localparam int unsigned PW = 2 * ADDR_WIDTH + INSTR_WIDTH;

  fetch_state_e           state_q, state_d;
  logic                   skid_vld_q, skid_vld_d;
  logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;

  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [ADDR_WIDTH-1:0]  skid_pc_plus4;
  logic                   req;
  logic                   ifid_load;
  logic                   ifid_flush;
  logic [PW-1:0]          ifid_din;
  logic [PW-1:0]          ifid_dout;

  assign pc_plus4      = pc_i + ADDR_WIDTH'(PC_STEP);
  assign skid_pc_plus4 = skid_pc_q + ADDR_WIDTH'(PC_STEP);

  // Any cycle without a load and without stall issues a bubble, so ID never
  // consumes the same IF/ID entry twice while the next fetch is in flight.
  always_comb begin
    state_d      = state_q;
    pc_next_o    = pc_i;
    req          = 1'b0;
    skid_vld_d   = skid_vld_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ifid_load    = 1'b0;
    ifid_flush   = !stall_i;
    ifid_din     = {pc_i, pc_plus4, imem.imem_rdata};

    if (redirect_i && (state_q != S_BOOT)) begin
      pc_next_o  = redirect_pc_i;
      ifid_flush = 1'b1;
      skid_vld_d = 1'b0;
    end

    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (!redirect_i) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          state_d = imem.imem_rvalid ? S_REQ : S_KILL;
        end else if (imem.imem_rvalid) begin
          pc_next_o = pc_plus4;
          if (!stall_i || !ifid_valid_o) begin
            ifid_load  = 1'b1;
            ifid_flush = 1'b0;
            state_d    = S_REQ;
          end else begin
            skid_vld_d   = 1'b1;
            skid_pc_d    = pc_i;
            skid_instr_d = imem.imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end
      S_KILL: begin
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_REQ;
        end else if (!stall_i) begin
          ifid_load  = skid_vld_q;
          ifid_flush = 1'b0;
          ifid_din   = {skid_pc_q, skid_pc_plus4, skid_instr_q};
          skid_vld_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase

    pc_next_o[1:0] = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      skid_vld_q   <= skid_vld_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  ifid_reg #(
    .DATA_WIDTH(PW)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .data_i  (ifid_din),
    .valid_o (ifid_valid_o),
    .data_o  (ifid_dout)
  );

  assign ifid_pc_o       = ifid_dout[PW-1 -: ADDR_WIDTH];
  assign ifid_pc_plus4_o = ifid_dout[INSTR_WIDTH +: ADDR_WIDTH];
  assign ifid_instr_o    = ifid_dout[INSTR_WIDTH-1:0];

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_i;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a local PC register and a hand-driven memory.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          ifid_valid;
  logic [AW-1:0] ifid_pc;
  logic [AW-1:0] ifid_pc_plus4;
  logic [IW-1:0] ifid_instr;

  int total = 0;
  int bad   = 0;

  if_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem ();

  if_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_i            (pc_q),
    .pc_next_o       (pc_next),
    .imem            (imem),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .ifid_valid_o    (ifid_valid),
    .ifid_pc_o       (ifid_pc),
    .ifid_pc_plus4_o (ifid_pc_plus4),
    .ifid_instr_o    (ifid_instr)
  );

  always #5 clk = ~clk;

  // PC register outside the DUT: loads pc_next every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_next;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [AW-1:0] rpc,
                       input logic rv, input logic [IW-1:0] rdat);
    stall            = st;
    redirect         = rd;
    redirect_pc      = rpc;
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rdat;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input fetch_state_e exp);
    chk(tag, 64'(dut.state_q), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, '0, 0, '0);
    step();
    step();
    chk("rst_valid", 64'(ifid_valid), 64'd0);
    chk("rst_pc", 64'(ifid_pc), 64'd0);
    chk("rst_pc4", 64'(ifid_pc_plus4), 64'd0);
    chk("rst_instr", 64'(ifid_instr), 64'd0);
    chk("rst_req", 64'(imem.imem_req), 64'd0);
    chk_state("rst_state", S_BOOT);

    // Boot cycle
    rst_n = 1'b1;
    drive(0, 0, '0, 0, '0);
    chk("boot_req", 64'(imem.imem_req), 64'd0);
    step();

    // Steady 1-cycle memory returning 0x13
    drive(0, 0, '0, 0, '0);
    chk_state("r0_state", S_REQ);
    chk("r0_req", 64'(imem.imem_req), 64'd1);
    chk("r0_addr", 64'(imem.imem_addr), 64'h0);
    chk("r0_pcn", 64'(pc_next), 64'h0);
    step();
    drive(0, 0, '0, 1, 32'h00000013);
    chk("w0_pcn", 64'(pc_next), 64'h4);
    step();
    chk("r1_valid", 64'(ifid_valid), 64'd1);
    chk("r1_pc", 64'(ifid_pc), 64'h0);
    chk("r1_pc4", 64'(ifid_pc_plus4), 64'h4);
    chk("r1_instr", 64'(ifid_instr), 64'h13);
    drive(0, 0, '0, 0, '0);
    chk("r1_addr", 64'(imem.imem_addr), 64'h4);
    chk("r1_req", 64'(imem.imem_req), 64'd1);
    step();
    chk("w1_bubble", 64'(ifid_valid), 64'd0);
    drive(0, 0, '0, 1, 32'h00000013);
    step();
    chk("r2_valid", 64'(ifid_valid), 64'd1);
    chk("r2_pc", 64'(ifid_pc), 64'h4);

    // Stall for 5 cycles while the 0x8 response arrives
    drive(1, 0, '0, 0, '0);
    chk("r2_addr", 64'(imem.imem_addr), 64'h8);
    step();
    chk("w2_hold_valid", 64'(ifid_valid), 64'd1);
    drive(1, 0, '0, 1, 32'h00800093);
    chk("w2_pcn", 64'(pc_next), 64'hC);
    step();
    for (int i = 0; i < 3; i++) begin
      chk_state("hold_state", S_HOLD);
      chk("hold_pc", 64'(ifid_pc), 64'h4);
      chk("hold_valid", 64'(ifid_valid), 64'd1);
      drive(1, 0, '0, 0, '0);
      chk("hold_req", 64'(imem.imem_req), 64'd0);
      step();
    end
    chk_state("hold_last", S_HOLD);
    drive(0, 0, '0, 0, '0);
    step();
    chk("r3_valid", 64'(ifid_valid), 64'd1);
    chk("r3_pc", 64'(ifid_pc), 64'h8);
    chk("r3_pc4", 64'(ifid_pc_plus4), 64'hC);
    chk("r3_instr", 64'(ifid_instr), 64'h00800093);
    drive(0, 0, '0, 0, '0);
    chk("r3_req", 64'(imem.imem_req), 64'd1);
    chk("r3_addr", 64'(imem.imem_addr), 64'hC);
    step();

    // Redirect to 0x100 while waiting on a 3-cycle memory
    drive(0, 0, '0, 0, '0);
    chk_state("w3_state", S_WAIT);
    step();
    drive(0, 1, 32'h00000100, 0, '0);
    chk("w3_redir_pcn", 64'(pc_next), 64'h100);
    step();
    chk_state("kill_state", S_KILL);
    chk("kill_valid", 64'(ifid_valid), 64'd0);
    drive(0, 0, '0, 1, 32'hDEADBEEF);
    chk("kill_req", 64'(imem.imem_req), 64'd0);
    step();
    chk_state("r4_state", S_REQ);
    chk("r4_valid", 64'(ifid_valid), 64'd0);
    drive(0, 0, '0, 0, '0);
    chk("r4_addr", 64'(imem.imem_addr), 64'h100);
    chk("r4_req", 64'(imem.imem_req), 64'd1);
    step();
    drive(0, 0, '0, 1, 32'h00000013);
    step();
    chk("r5_valid", 64'(ifid_valid), 64'd1);
    chk("r5_pc", 64'(ifid_pc), 64'h100);
    chk("r5_instr", 64'(ifid_instr), 64'h13);

    // Redirect (unaligned 0x203) together with rvalid under stall
    drive(1, 0, '0, 0, '0);
    step();
    chk("w5_valid", 64'(ifid_valid), 64'd1);
    drive(1, 1, 32'h00000203, 1, 32'h00000055);
    chk("w5_pcn", 64'(pc_next), 64'h200);
    step();
    chk("r6_valid", 64'(ifid_valid), 64'd0);
    chk_state("r6_state", S_REQ);
    drive(0, 0, '0, 0, '0);
    chk("r6_addr", 64'(imem.imem_addr), 64'h200);
    chk("r6_req", 64'(imem.imem_req), 64'd1);
    step();

    // Wrap at the top of the address space
    drive(0, 1, 32'hFFFFFFFC, 1, 32'h00000066);
    step();
    chk("r7_valid", 64'(ifid_valid), 64'd0);
    drive(0, 0, '0, 0, '0);
    chk("r7_addr", 64'(imem.imem_addr), 64'hFFFFFFFC);
    step();
    drive(0, 0, '0, 1, 32'h00000013);
    chk("w7_pcn_wrap", 64'(pc_next), 64'h0);
    step();
    chk("r8_valid", 64'(ifid_valid), 64'd1);
    chk("r8_pc", 64'(ifid_pc), 64'hFFFFFFFC);
    chk("r8_pc4_wrap", 64'(ifid_pc_plus4), 64'h0);
    drive(0, 0, '0, 0, '0);
    chk("r8_addr", 64'(imem.imem_addr), 64'h0);
    step();

    // Reset in S_WAIT, then stale responses after release
    chk_state("w8_state", S_WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(ifid_valid), 64'd0);
    chk("mrst_pc", 64'(ifid_pc), 64'd0);
    chk("mrst_pc4", 64'(ifid_pc_plus4), 64'd0);
    chk("mrst_instr", 64'(ifid_instr), 64'd0);
    chk("mrst_req", 64'(imem.imem_req), 64'd0);
    chk("mrst_pcn", 64'(pc_next), 64'd0);
    chk_state("mrst_state", S_BOOT);
    step();
    rst_n = 1'b1;
    drive(0, 0, '0, 1, 32'h00000BAD);
    chk("rb_req", 64'(imem.imem_req), 64'd0);
    chk("rb_pcn", 64'(pc_next), 64'h0);
    step();
    drive(0, 0, '0, 1, 32'h00000BAD);
    chk("rr_req", 64'(imem.imem_req), 64'd1);
    chk("rr_addr", 64'(imem.imem_addr), 64'h0);
    chk("rr_pcn", 64'(pc_next), 64'h0);
    step();
    chk("rw_valid", 64'(ifid_valid), 64'd0);
    drive(0, 0, '0, 1, 32'h00000013);
    chk("rw_pcn", 64'(pc_next), 64'h4);
    step();
    chk("rf_valid", 64'(ifid_valid), 64'd1);
    chk("rf_pc", 64'(ifid_pc), 64'h0);
    chk("rf_instr", 64'(ifid_instr), 64'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
